// File: rtl/bip_pkg.sv
// Shared constants for the BIP sequencer: field widths, opcodes, FSM encoding,
// datapath select codes and the decoded control word.
package bip_pkg;

  localparam int NB_INSTRUCTION_DEF = 16;
  localparam int NB_ADDR_DEF        = 11;
  localparam int OPCODE_W           = 5;

  localparam logic [OPCODE_W-1:0] OPC_HLT  = 5'd0;
  localparam logic [OPCODE_W-1:0] OPC_STO  = 5'd1;
  localparam logic [OPCODE_W-1:0] OPC_LD   = 5'd2;
  localparam logic [OPCODE_W-1:0] OPC_LDI  = 5'd3;
  localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OPC_ADDI = 5'd5;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'd6;
  localparam logic [OPCODE_W-1:0] OPC_SUBI = 5'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic       SEL_B_RAM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;
  localparam logic       OP_ADD    = 1'b0;
  localparam logic       OP_SUB    = 1'b1;

  typedef struct packed {
    logic       needs_mem;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder; illegal opcodes decode to an all-zero word (NOP).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_HLT: ctrl.halt = 1'b1;
      OPC_STO: ctrl.wr_ram = 1'b1;
      OPC_LD: begin
        ctrl.needs_mem = 1'b1;
        ctrl.wr_acc    = 1'b1;
        ctrl.sel_a     = SEL_A_RAM;
      end
      OPC_LDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_IMM;
      end
      OPC_ADD, OPC_SUB: begin
        ctrl.needs_mem = 1'b1;
        ctrl.wr_acc    = 1'b1;
        ctrl.sel_a     = SEL_A_ALU;
        ctrl.sel_b     = SEL_B_RAM;
        ctrl.op        = (opcode == OPC_SUB) ? OP_SUB : OP_ADD;
      end
      OPC_ADDI, OPC_SUBI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.op     = (opcode == OPC_SUBI) ? OP_SUB : OP_ADD;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP instruction sequencer: owns pc, the fetched instruction and the run/halt FSM,
// and drives RAM strobes and accumulator datapath controls from registered state only.
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = NB_INSTRUCTION_DEF,
  parameter int NB_ADDR        = NB_ADDR_DEF,
  parameter int NB_OPCODE      = OPCODE_W,
  parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_INSTRUCTION-1:0] i_rom_data,
  output logic [NB_ADDR-1:0]        o_rom_addr,
  output logic [NB_ADDR-1:0]        o_ram_addr,
  output logic                      o_ram_rd_enable,
  output logic                      o_ram_wr_enable,
  output logic [NB_OPERAND-1:0]     o_operand,
  output logic [1:0]                o_sel_a,
  output logic                      o_sel_b,
  output logic                      o_op,
  output logic                      o_wr_acc,
  output logic                      o_busy,
  output logic                      o_halted
);

  logic [2:0]            state_reg, state_next;
  logic [NB_ADDR-1:0]    pc_reg, pc_next;
  logic [NB_OPERAND-1:0] operand_reg;
  ctrl_t                 ctrl_reg;
  ctrl_t                 fetch_ctrl;
  logic                  in_exec;

  // The opcode is decoded once while it is on the ROM bus; only the control word is kept,
  // so EXEC strobes never see the ROM input combinationally.
  bip_decoder u_decoder (
    .opcode (i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE]),
    .ctrl   (fetch_ctrl)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH: state_next = fetch_ctrl.needs_mem ? ST_MEM : ST_EXEC;
      ST_MEM:   state_next = ST_EXEC;
      ST_EXEC: begin
        if (ctrl_reg.halt) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
          pc_next    = pc_reg + NB_ADDR'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      operand_reg <= '0;
      ctrl_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (state_reg == ST_FETCH) begin
        operand_reg <= i_rom_data[NB_OPERAND-1:0];
        ctrl_reg    <= fetch_ctrl;
      end
    end
  end

  assign in_exec         = (state_reg == ST_EXEC);
  assign o_rom_addr      = pc_reg;
  assign o_ram_addr      = operand_reg[NB_ADDR-1:0];
  assign o_operand       = operand_reg;
  assign o_ram_rd_enable = (state_reg == ST_MEM) && ctrl_reg.needs_mem;
  assign o_ram_wr_enable = in_exec && ctrl_reg.wr_ram;
  assign o_wr_acc        = in_exec && ctrl_reg.wr_acc;
  // Selects are forced to zero whenever no accumulator load is in progress.
  assign o_sel_a         = o_wr_acc ? ctrl_reg.sel_a : SEL_A_RAM;
  assign o_sel_b         = o_wr_acc ? ctrl_reg.sel_b : SEL_B_RAM;
  assign o_op            = o_wr_acc ? ctrl_reg.op    : OP_ADD;
  assign o_busy          = (state_reg == ST_FETCH) || (state_reg == ST_MEM) || in_exec;
  assign o_halted        = (state_reg == ST_HALT);

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: ROM/RAM/accumulator around the DUT, a per-instruction cycle
// model checked every cycle, and an instruction-set interpreter for end results.
module tb_bip_control;

  localparam logic [4:0] T_HLT = 5'd0, T_STO = 5'd1, T_LD = 5'd2, T_LDI = 5'd3;
  localparam logic [4:0] T_ADD = 5'd4, T_SUB = 5'd6;

  typedef struct packed {
    logic [10:0] rom_addr;
    logic [10:0] ram_addr;
    logic [10:0] operand;
    logic        rd;
    logic        wr;
    logic        wr_acc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        busy;
    logic        halted;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rom_data;
  logic [10:0] o_rom_addr, o_ram_addr, o_operand;
  logic        o_ram_rd_enable, o_ram_wr_enable, o_sel_b, o_op, o_wr_acc, o_busy, o_halted;
  logic [1:0]  o_sel_a;

  logic [15:0] rom [2048];
  logic [15:0] ram [2048];
  logic [15:0] iss_ram [2048];
  logic [15:0] acc = '0;
  logic [15:0] ram_q = '0;
  logic [15:0] alu_b;

  int n_checks = 0;
  int n_fail = 0;

  bip_control dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_start         (start),
    .i_rom_data      (rom_data),
    .o_rom_addr      (o_rom_addr),
    .o_ram_addr      (o_ram_addr),
    .o_ram_rd_enable (o_ram_rd_enable),
    .o_ram_wr_enable (o_ram_wr_enable),
    .o_operand       (o_operand),
    .o_sel_a         (o_sel_a),
    .o_sel_b         (o_sel_b),
    .o_op            (o_op),
    .o_wr_acc        (o_wr_acc),
    .o_busy          (o_busy),
    .o_halted        (o_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sext(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] opd);
    return {opc, opd};
  endfunction

  // Program memory and accumulator datapath driven purely by the DUT's strobes.
  assign rom_data = rom[o_rom_addr];
  assign alu_b    = o_sel_b ? sext(o_operand) : ram_q;

  always @(posedge clk) begin
    if (o_ram_rd_enable) ram_q <= ram[o_ram_addr];
    if (o_ram_wr_enable) ram[o_ram_addr] <= acc;
    if (o_wr_acc) begin
      case (o_sel_a)
        2'd0:    acc <= ram_q;
        2'd1:    acc <= sext(o_operand);
        default: acc <= o_op ? acc - alu_b : acc + alu_b;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle model: each instruction expands into its list of expected output cycles.
  outs_t       exp_q[$];
  outs_t       exp_now = '0;
  int          m_status = 0;          // 0 idle, 1 running, 2 halted
  logic [10:0] m_pc = '0;
  logic [10:0] m_opnd = '0;
  logic [4:0]  m_last_opc = '0;

  function automatic outs_t quiet(input logic [10:0] pc, input logic [10:0] opnd);
    outs_t o;
    o = '0;
    o.rom_addr = pc;
    o.ram_addr = opnd;
    o.operand  = opnd;
    return o;
  endfunction

  task automatic plan_instr();
    logic [15:0] w;
    logic [4:0]  opc;
    outs_t       c;
    w = rom[m_pc];
    opc = w[15:11];
    c = quiet(m_pc, m_opnd);
    c.busy = 1'b1;
    exp_q.push_back(c);
    m_opnd = w[10:0];
    m_last_opc = opc;
    if (opc == T_LD || opc == T_ADD || opc == T_SUB) begin
      c = quiet(m_pc, m_opnd);
      c.busy = 1'b1;
      c.rd = 1'b1;
      exp_q.push_back(c);
    end
    c = quiet(m_pc, m_opnd);
    c.busy = 1'b1;
    case (opc)
      5'd1: c.wr = 1'b1;
      5'd2: c.wr_acc = 1'b1;
      5'd3: begin c.wr_acc = 1'b1; c.sel_a = 2'd1; end
      5'd4: begin c.wr_acc = 1'b1; c.sel_a = 2'd2; end
      5'd5: begin c.wr_acc = 1'b1; c.sel_a = 2'd2; c.sel_b = 1'b1; end
      5'd6: begin c.wr_acc = 1'b1; c.sel_a = 2'd2; c.op = 1'b1; end
      5'd7: begin c.wr_acc = 1'b1; c.sel_a = 2'd2; c.sel_b = 1'b1; c.op = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(c);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_status = 0;
      m_pc = '0;
      m_opnd = '0;
      exp_q.delete();
    end else begin
      if (m_status != 1) begin
        if (start) begin
          m_status = 1;
          m_pc = '0;
        end
      end else begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          if (m_last_opc == T_HLT) m_status = 2;
          else m_pc = m_pc + 11'd1;
        end
      end
      if (m_status == 1 && exp_q.size() == 0) plan_instr();
    end
    if (m_status == 1) begin
      exp_now = exp_q[0];
    end else begin
      exp_now = quiet(m_pc, m_opnd);
      exp_now.halted = (m_status == 2);
    end
  end

  initial forever begin
    outs_t act;
    @(negedge clk);
    act = {o_rom_addr, o_ram_addr, o_operand, o_ram_rd_enable, o_ram_wr_enable, o_wr_acc,
           o_sel_a, o_sel_b, o_op, o_busy, o_halted};
    n_checks++;
    if (act !== exp_now) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, act, exp_now);
    end
  end

  // Instruction-level interpreter giving final accumulator and RAM contents.
  task automatic iss_run(output logic [15:0] acc_o, output bit done);
    logic [15:0] a;
    logic [15:0] w;
    logic [10:0] opd;
    int          pc;
    a = '0;
    pc = 0;
    done = 1'b0;
    for (int s = 0; s < 4096 && !done; s++) begin
      w = rom[pc];
      opd = w[10:0];
      case (w[15:11])
        5'd0: done = 1'b1;
        5'd1: iss_ram[opd] = a;
        5'd2: a = iss_ram[opd];
        5'd3: a = sext(opd);
        5'd4: a = a + iss_ram[opd];
        5'd5: a = a + sext(opd);
        5'd6: a = a - iss_ram[opd];
        5'd7: a = a - sext(opd);
        default: ;
      endcase
      if (!done) pc = (pc + 1) % 2048;
    end
    acc_o = a;
  endtask

  task automatic run_prog(input bit jitter, input int budget, output int cycles, output bit ok);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cycles = 0;
    start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!o_halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
      start = (jitter && o_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    ok = o_halted;
  endtask

  initial begin
    logic [15:0] iss_acc;
    bit          iss_done;
    bit          ok;
    int          cyc;
    int          len;
    int          r;
    logic [4:0]  opc;
    logic [10:0] opd;

    for (int a = 0; a < 2048; a++) begin
      rom[a] = '0;
      ram[a] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_rom_addr", 32'(o_rom_addr), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_halted", 32'(o_halted), 32'd0);

    // LDI 5; ADDI 3; STO 10; HLT
    rom[0] = enc(T_LDI, 11'd5);
    rom[1] = enc(5'd5, 11'd3);
    rom[2] = enc(T_STO, 11'd10);
    rom[3] = enc(T_HLT, 11'd0);
    iss_ram = ram;
    iss_run(iss_acc, iss_done);
    check("p1_model_ram10", 32'(iss_ram[10]), 32'd8);
    run_prog(1'b0, 200, cyc, ok);
    check("p1_halted", 32'(ok), 32'd1);
    check("p1_cycles", 32'(cyc), 32'd8);
    check("p1_pc", 32'(o_rom_addr), 32'd3);
    check("p1_ram10", 32'(ram[10]), 32'd8);
    $display("program p1 cycles=%0d acc=%0h ram10=%0h", cyc, acc, ram[10]);

    // LD 4; SUB 5; HLT
    ram[4] = 16'd9;
    ram[5] = 16'd2;
    rom[0] = enc(T_LD, 11'd4);
    rom[1] = enc(T_SUB, 11'd5);
    rom[2] = enc(T_HLT, 11'd0);
    iss_ram = ram;
    iss_run(iss_acc, iss_done);
    check("p2_model_acc", 32'(iss_acc), 32'd7);
    run_prog(1'b0, 200, cyc, ok);
    check("p2_halted", 32'(ok), 32'd1);
    check("p2_cycles", 32'(cyc), 32'd8);
    check("p2_acc", 32'(acc), 32'd7);
    $display("program p2 cycles=%0d acc=%0h", cyc, acc);

    // Illegal opcode 0x1F then HLT
    rom[0] = 16'hF800;
    rom[1] = enc(T_HLT, 11'd0);
    run_prog(1'b0, 200, cyc, ok);
    check("p3_halted", 32'(ok), 32'd1);
    check("p3_cycles", 32'(cyc), 32'd4);
    check("p3_pc", 32'(o_rom_addr), 32'd1);
    check("p3_acc_kept", 32'(acc), 32'd7);
    $display("program p3 cycles=%0d pc=%0d", cyc, o_rom_addr);

    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(4, 12);
      for (int a = 0; a < 16; a++) ram[a] = 16'($urandom);
      rom[0] = enc(T_LDI, 11'($urandom));
      for (int i = 1; i < len; i++) begin
        r = $urandom_range(0, 9);
        opc = (r < 7) ? 5'(r + 1) : 5'($urandom_range(8, 31));
        opd = (opc == T_STO || opc == T_LD || opc == T_ADD || opc == T_SUB) ?
              11'($urandom_range(0, 15)) : 11'($urandom);
        rom[i] = enc(opc, opd);
      end
      rom[len] = enc(T_HLT, 11'd0);
      iss_ram = ram;
      iss_run(iss_acc, iss_done);
      run_prog(1'b1, 500, cyc, ok);
      check("rnd_halted", 32'(ok), 32'd1);
      check("rnd_pc", 32'(o_rom_addr), 32'(len));
      check("rnd_acc", 32'(acc), 32'(iss_acc));
      for (int a = 0; a < 16; a++) check("rnd_ram", 32'(ram[a]), 32'(iss_ram[a]));
      $display("program rnd%0d len=%0d cycles=%0d acc=%0h", p, len, cyc, acc);
    end

    // Reset during MEM of ADD: LDI 1; ADD 4; HLT
    rom[0] = enc(T_LDI, 11'd1);
    rom[1] = enc(T_ADD, 11'd4);
    rom[2] = enc(T_HLT, 11'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!o_ram_rd_enable && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_mem", 32'(o_ram_rd_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_enable", 32'(o_ram_rd_enable), 32'd0);
    check("rst_wr_acc", 32'(o_wr_acc), 32'd0);
    check("rst_wr_enable", 32'(o_ram_wr_enable), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_acc_untouched", 32'(acc), 32'd1);
    rst_n = 1'b1;
    $display("reset during MEM acc=%0h", acc);

    // NOP-filled ROM: run to pc 2047 and watch the wrap, with start noise throughout
    for (int a = 0; a < 2048; a++) rom[a] = 16'h4000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 4094; c++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("wrap_pc_top", 32'(o_rom_addr), 32'd2047);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("wrap_pc_zero", 32'(o_rom_addr), 32'd0);
    check("wrap_busy", 32'(o_busy), 32'd1);
    $display("wrap run pc=%0d", o_rom_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_control.md
# bip_control

Instruction sequencer for the BIP processor: fetches 16-bit instructions from the combinational program ROM, decodes the 5-bit opcode, and drives the accumulator datapath select/write strobes and the data-RAM read/write enables. It sits inside the CPU between program ROM, data RAM and the accumulator/ALU datapath. It owns the program counter and the run/halt state.

## Interface
- NB_INSTRUCTION, 16, instruction word width
- NB_ADDR, 11, ROM/RAM address width
- NB_OPCODE, 5, opcode field width (instruction MSBs)
- NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand field width (instruction LSBs)
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  run request, sampled in IDLE/HALT only
- i_rom_data  in  NB_INSTRUCTION  instruction at o_rom_addr, same cycle
- o_rom_addr  out  NB_ADDR  program counter
- o_ram_addr  out  NB_ADDR  data address = IR operand[NB_ADDR-1:0]
- o_ram_rd_enable  out  1  RAM read strobe, data valid next cycle
- o_ram_wr_enable  out  1  RAM write strobe (accumulator is write data)
- o_operand  out  NB_OPERAND  IR operand field, raw; datapath sign-extends
- o_sel_a  out  2  accumulator input: 0 RAM data, 1 immediate, 2 ALU result
- o_sel_b  out  1  ALU operand B: 0 RAM data, 1 immediate
- o_op  out  1  ALU op: 0 add, 1 subtract
- o_wr_acc  out  1  accumulator load strobe
- o_busy  out  1  high in FETCH/MEM/EXEC
- o_halted  out  1  high in HALT

## Operation
- Opcodes: HLT 0, STO 1, LD 2, LDI 3, ADD 4, ADDI 5, SUB 6, SUBI 7; 8..31 illegal, executed as NOP.
- States: IDLE, FETCH, MEM, EXEC, HALT.
- IDLE: pc=0; i_start=1 -> FETCH.
- FETCH: IR <= i_rom_data; opcode in {LD, ADD, SUB} -> MEM, else -> EXEC.
- MEM: o_ram_rd_enable=1 with o_ram_addr=operand; -> EXEC.
- EXEC strobes, one cycle: STO wr_enable; LD wr_acc, sel_a=0; LDI wr_acc, sel_a=1; ADD/SUB wr_acc, sel_a=2, sel_b=0, op=0/1; ADDI/SUBI wr_acc, sel_a=2, sel_b=1, op=0/1; NOP/HLT none.
- Leaving EXEC: HLT -> HALT with pc unchanged; otherwise pc <= pc+1 -> FETCH.
- HALT: i_start=1 -> FETCH with pc reset to 0; otherwise stay.
- i_start is ignored in FETCH/MEM/EXEC.
- pc wraps from 2^NB_ADDR-1 to 0 without a flag.
- Outputs are decoded from state and IR registers only; there is no combinational input-to-output path.
- Strobes default to 0; o_sel_a, o_sel_b and o_op default to 0 when no strobe is active.

## Timing
- Reset (async assert, sync release): state IDLE, pc=0, IR=0. All outputs 0: o_rom_addr, o_ram_addr, o_operand, selects, strobes, o_busy, o_halted.
- Reset asserted mid-instruction aborts immediately; no write strobe may be active after assertion.
- Cycles per instruction: 2 (FETCH, EXEC) for STO, LDI, ADDI, SUBI, HLT and illegal opcodes; 3 (FETCH, MEM, EXEC) for LD, ADD and SUB.
- Start: i_start sampled high at edge N moves state to FETCH at N. The first instruction fetches during cycle N+1.
- o_ram_addr is stable from MEM through EXEC.
- RAM read data is consumed in EXEC, one cycle after the MEM strobe.
- o_halted rises on the edge leaving EXEC of HLT.

## Structure
- bip_pkg: opcode localparams, state encoding, SEL_A_* / SEL_B_* codes, OP_ADD/OP_SUB.
- bip_decoder: one combinational sub-module mapping opcode to {needs_mem, sel_a, sel_b, op, wr_acc, wr_ram, halt}.
- bip_control holds the FSM, pc and IR, and gates decoder outputs by state.

## Test plan
- Reset with i_start=0 for 10 cycles -> all outputs 0, o_busy=0, o_rom_addr stays 0.
- Program LDI 5; ADDI 3; STO 10; HLT, with a model ACC/RAM -> RAM[10]=8. o_halted rises 8 cycles after first FETCH; pc=3 in HALT.
- Program LD 4; SUB 5; HLT with RAM[4]=9, RAM[5]=2 -> ACC=7. Each of LD and SUB shows a MEM cycle with rd_enable=1 and addr 4/5, and takes 3 cycles.
- Illegal opcode 0x1F, then HLT -> no strobes during the illegal EXEC; pc advances 0->1; halts at pc=1.
- Async reset asserted during MEM of an ADD -> same-cycle return to IDLE, rd_enable and wr_acc 0, no accumulator write.
- ROM fully NOP-filled with pc preloaded to 2047 -> next pc 0 (wrap); i_start pulses during FETCH have no effect.
